// File: rtl/sg13g2_latch_regfile.sv
// sg13g2_latch_regfile: multi-word storage built from high-transparent latches.
// Writes are staged in flops on the rising edge. The staged word is then
// copied into its latch row while clk is low. After reset, a built-in
// sequencer zeroes every word before ready rises. Reads are either
// combinational (with optional bypass of the staged write) or registered
// (with mandatory forwarding of the staged write).
module sg13g2_latch_regfile #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AW       = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_t;

  // Address limit is one bit wider, so DEPTH itself is representable
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);

  state_t                      state_r;
  logic [AW-1:0]               ptr_r;
  logic                        wv_q;
  logic [AW-1:0]               wa_q;
  logic [WIDTH-1:0]            wd_q;
  logic [DEPTH-1:0]            gate_s;
  logic [DEPTH-1:0][WIDTH-1:0] mem_s;
  logic [WIDTH-1:0]            mem_rd_s;
  logic                        wr_ok_s;
  logic                        rd_ok_s;
  logic                        hit_s;

  assign wr_ok_s = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok_s = ({1'b0, rd_addr} < DEPTH_W);
  assign hit_s   = wv_q && (wa_q == rd_addr);

  // Clear sequencer and write staging; staging only moves while clk is high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLR;
      ptr_r   <= '0;
      ready   <= 1'b0;
      wv_q    <= 1'b1;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      case (state_r)
        CLR: begin
          wv_q <= 1'b1;
          wa_q <= ptr_r;
          wd_q <= '0;
          if (ptr_r == LAST_W) begin
            state_r <= RUN;
            ready   <= 1'b1;
          end else begin
            ptr_r <= ptr_r + AW'(1);
          end
        end
        RUN: begin
          if (wr_en && wr_ok_s) begin
            wv_q <= 1'b1;
            wa_q <= wr_addr;
            wd_q <= wr_data;
          end else begin
            wv_q <= 1'b0;
          end
        end
        default: begin
          state_r <= CLR;
          ptr_r   <= '0;
          ready   <= 1'b0;
          wv_q    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [WIDTH-1:0] word_r;

    // Gate opens only in the low phase, and its inputs are stable then
    assign gate_s[i] = ~clk & wv_q & (wa_q == AW'(i));

    // Storage latch for one word; transparent while its gate is open
    always_latch begin
      if (gate_s[i]) begin
        word_r <= wd_q;
      end
    end

    assign mem_s[i] = word_r;
  end

  // Read mux over the latch rows; out-of-range addresses select nothing
  always_comb begin
    mem_rd_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        mem_rd_s = mem_s[i];
      end else begin
        mem_rd_s = mem_rd_s;
      end
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [WIDTH-1:0] rd_q;

    // Registered read; the staged write is forwarded to avoid racing latch close
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else if (ready && rd_ok_s) begin
        rd_q <= hit_s ? wd_q : mem_rd_s;
      end else begin
        rd_q <= '0;
      end
    end

    assign rd_data = rd_q;
  end else begin : g_rd_comb
    logic [WIDTH-1:0] rd_s;

    // Combinational read with optional bypass of the staged write
    always_comb begin
      rd_s = '0;
      if (ready && rd_ok_s) begin
        if ((BYPASS != 0) && hit_s) begin
          rd_s = wd_q;
        end else begin
          rd_s = mem_rd_s;
        end
      end else begin
        rd_s = '0;
      end
    end

    assign rd_data = rd_s;
  end

endmodule

// File: tb/tb_sg13g2_latch_regfile.sv
// Testbench for sg13g2_latch_regfile. Three configurations run side by side:
//   a: DEPTH=4, combinational read with bypass
//   b: DEPTH=4, registered read
//   c: DEPTH=3, combinational read with bypass
// All three share the same inputs. A word-array reference model predicts
// every output.
module tb_sg13g2_latch_regfile;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic       ready_a, ready_b, ready_c;
  logic [7:0] rd_data_a, rd_data_b, rd_data_c;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [7:0] m4 [4];
  logic [7:0] m3 [3];
  int         cnt4, cnt3;
  logic       rdy4, rdy3;
  logic [7:0] exp_a, exp_b, exp_c;

  sg13g2_latch_regfile #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .READ_REG(0)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a));

  sg13g2_latch_regfile #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .READ_REG(1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b));

  sg13g2_latch_regfile #(.WIDTH(8), .DEPTH(3), .BYPASS(1), .READ_REG(0)) dut_c (
    .clk(clk), .rst(rst), .ready(ready_c), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one posedge, update the model from the sampled inputs, settle 1ns
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) m4[i] = 8'h00;
      for (int i = 0; i < 3; i++) m3[i] = 8'h00;
      cnt4  = 0;
      cnt3  = 0;
      rdy4  = 1'b0;
      rdy3  = 1'b0;
      exp_b = 8'h00;
    end else begin
      exp_b = rdy4 ? m4[rd_addr] : 8'h00;
      if (wr_en && rdy4) m4[wr_addr] = wr_data;
      if (wr_en && rdy3 && (wr_addr < 2'd3)) m3[wr_addr] = wr_data;
      if (!rdy4) begin
        cnt4 = cnt4 + 1;
        rdy4 = (cnt4 == 4);
      end
      if (!rdy3) begin
        cnt3 = cnt3 + 1;
        rdy3 = (cnt3 == 3);
      end
    end
    exp_a = rdy4 ? m4[rd_addr] : 8'h00;
    exp_c = (rdy3 && (rd_addr < 2'd3)) ? m3[rd_addr] : 8'h00;
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra);
    wr_en   = en;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 2'd0, 8'h00, 2'(n));
      tick();
      n_total++;
      if (ready_a !== 1'b0 || rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || rd_data_c !== 8'h00) begin
        $display("FAIL reset_hold: ready_a=%b rd a/b/c=%h/%h/%h required ready 0 and data 00",
                 ready_a, rd_data_a, rd_data_b, rd_data_c);
      end else n_pass++;
    end
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      n_total++;
      if (ready_a !== (n == 4) || ready_b !== (n == 4) || ready_c !== (n >= 3)) begin
        $display("FAIL ready_rise edge %0d: a/b/c=%b%b%b required %b%b%b",
                 n, ready_a, ready_b, ready_c, (n == 4), (n == 4), (n >= 3));
      end else n_pass++;
    end
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 2'd0, 8'h00, 2'(a));
      tick();
      tick();
      n_total++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || rd_data_c !== 8'h00) begin
        $display("FAIL cleared addr %0d: a/b/c=%h/%h/%h required 00", a, rd_data_a, rd_data_b, rd_data_c);
      end else n_pass++;
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 2'd1, 8'hA5, 2'd1);
    tick();
    n_total++;
    if (rd_data_a !== 8'hA5) $display("FAIL bypass_same_cycle: got %h required a5", rd_data_a);
    else n_pass++;
    drive(1'b1, 2'd2, 8'h3C, 2'd1);
    tick();
    n_total++;
    if (rd_data_a !== 8'hA5) $display("FAIL read_addr1: got %h required a5", rd_data_a);
    else n_pass++;
    drive(1'b0, 2'd0, 8'h00, 2'd2);
    tick();
    n_total++;
    if (rd_data_a !== 8'h3C || rd_data_c !== 8'h3C) begin
      $display("FAIL read_addr2: a=%h c=%h required 3c", rd_data_a, rd_data_c);
    end else n_pass++;
    drive(1'b0, 2'd0, 8'h00, 2'd0);
    tick();
    n_total++;
    if (rd_data_a !== 8'h00) $display("FAIL read_addr0: got %h required 00", rd_data_a);
    else n_pass++;
  endtask

  task automatic test_registered_read();
    drive(1'b0, 2'd0, 8'h00, 2'd3);
    tick();
    drive(1'b1, 2'd3, 8'h5A, 2'd3);
    tick();
    n_total++;
    if (rd_data_b !== 8'h00) $display("FAIL rreg_before_write: got %h required 00", rd_data_b);
    else n_pass++;
    drive(1'b0, 2'd0, 8'h00, 2'd3);
    tick();
    n_total++;
    if (rd_data_b !== 8'h5A) $display("FAIL rreg_forward: got %h required 5a", rd_data_b);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    // write to address 3 exists only in the DEPTH=4 instances
    drive(1'b1, 2'd3, 8'h99, 2'd3);
    tick();
    drive(1'b0, 2'd0, 8'h00, 2'd3);
    tick();
    n_total++;
    if (rd_data_c !== 8'h00 || rd_data_a !== 8'h99) begin
      $display("FAIL oob_write: c=%h required 00, a=%h required 99", rd_data_c, rd_data_a);
    end else n_pass++;
    // last write wins
    drive(1'b1, 2'd0, 8'hFF, 2'd0);
    tick();
    drive(1'b1, 2'd0, 8'h01, 2'd0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 2'd0);
    tick();
    n_total++;
    if (rd_data_a !== 8'h01 || rd_data_b !== 8'h01 || rd_data_c !== 8'h01) begin
      $display("FAIL last_wins: a/b/c=%h/%h/%h required 01", rd_data_a, rd_data_b, rd_data_c);
    end else n_pass++;
    // writes during the clear sequence are dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 2'd1, 8'hEE, 2'd1);
    for (int n = 0; n < 3; n++) tick();
    drive(1'b0, 2'd0, 8'h00, 2'd1);
    for (int n = 0; n < 3; n++) tick();
    n_total++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || rd_data_c !== 8'h00) begin
      $display("FAIL clr_write_drop: a/b/c=%h/%h/%h required 00", rd_data_a, rd_data_b, rd_data_c);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 2'(a), 8'(8'h11 * (a + 1)), 2'(a));
      tick();
    end
    drive(1'b1, 2'd2, 8'h77, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 2'd2);
    for (int n = 0; n < 5; n++) begin
      tick();
      n_total++;
      if (rd_data_a === 8'h77 || rd_data_b === 8'h77 || rd_data_c === 8'h77) begin
        $display("FAIL stale_77: a/b/c=%h/%h/%h required not 77", rd_data_a, rd_data_b, rd_data_c);
      end else n_pass++;
    end
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 2'd0, 8'h00, 2'(a));
      tick();
      tick();
      n_total++;
      if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || rd_data_c !== 8'h00) begin
        $display("FAIL mid_reset_clear addr %0d: a/b/c=%h/%h/%h required 00",
                 a, rd_data_a, rd_data_b, rd_data_c);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            2'($urandom_range(0, 3)));
      tick();
      n_total++;
      if (rd_data_a !== exp_a || rd_data_b !== exp_b || rd_data_c !== exp_c ||
          ready_a !== rdy4 || ready_b !== rdy4 || ready_c !== rdy3) begin
        $display("FAIL random cycle %0d: rd a/b/c=%h/%h/%h rdy=%b%b%b required %h/%h/%h rdy=%b%b%b",
                 n, rd_data_a, rd_data_b, rd_data_c, ready_a, ready_b, ready_c,
                 exp_a, exp_b, exp_c, rdy4, rdy4, rdy3);
      end else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 2'd0);
    cnt4 = 0;
    cnt3 = 0;
    rdy4 = 1'b0;
    rdy3 = 1'b0;
    exp_a = 8'h00;
    exp_b = 8'h00;
    exp_c = 8'h00;
    for (int i = 0; i < 4; i++) m4[i] = 8'h00;
    for (int i = 0; i < 3; i++) m3[i] = 8'h00;
    test_reset();
    test_write_read();
    test_registered_read();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
